motor_ramp_ctrl: RTL and testbench

- Per-motor command stage that sits directly upstream of the PWM counter and drives its en_dir1, en_dir2 and speed[7:0] inputs.
- Accepts direction/speed targets from the drive-mode logic (Bluetooth, line-seek, obstacle avoidance) and ramps the speed toward the target at a fixed slew rate.
- On a direction reversal it forces a ramp to zero, then a dead time with both directions disabled, before enabling the new direction.
- Guarantees en_dir1 and en_dir2 are never high together.

---
 rtl/motor_ramp_ctrl.sv | 175 +++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// Per-motor command stage: ramps speed toward a direction/speed target, forces
// decel-to-zero plus a dead time on reversal, and never drives both enables.
module motor_ramp_ctrl #(
    parameter int unsigned RAMP_DIV    = 50000,
    parameter int unsigned STEP        = 4,
    parameter int unsigned DEAD_CYCLES = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dir,
    input  logic [7:0] cmd_speed,
    input  logic       estop,
    output logic       en_dir1,
    output logic       en_dir2,
    output logic [7:0] speed,
    output logic       busy
);

    localparam int unsigned PrescW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DeadW  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [PrescW-1:0] PrescMax = PrescW'(RAMP_DIV - 1);
    localparam logic [DeadW-1:0]  DeadLoad = DeadW'(DEAD_CYCLES - 1);
    localparam logic [8:0]        Step9    = 9'(STEP);

    localparam logic [1:0] DirStop = 2'b00;
    localparam logic [1:0] DirFwd  = 2'b01;
    localparam logic [1:0] DirRev  = 2'b10;
    localparam logic [1:0] DirRsvd = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDecel, StDead} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cur_dir_q, cur_dir_d;
    logic [1:0]        tgt_dir_q, tgt_dir_d;
    logic [7:0]        tgt_speed_q, tgt_speed_d;
    logic [7:0]        speed_q, speed_d;
    logic [PrescW-1:0] presc_q;
    logic [DeadW-1:0]  dead_q, dead_d;
    logic              en1_q, en1_d;
    logic              en2_q, en2_d;
    logic              tick;

    // Free-running prescaler; only reset clears it, commands never do.
    assign tick = (presc_q == PrescMax);

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PrescW'(1);
        end
    end

    // Ramp arithmetic in 9 bits so neither direction can wrap.
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] up_to_tgt;
    logic [7:0] dn_to_tgt;
    logic [7:0] dn_to_zero;

    assign sum9       = {1'b0, speed_q} + Step9;
    assign diff9      = {1'b0, speed_q} - Step9;
    assign up_to_tgt  = (sum9 >= {1'b0, tgt_speed_q}) ? tgt_speed_q : sum9[7:0];
    assign dn_to_tgt  = (diff9[8] || (diff9[7:0] <= tgt_speed_q)) ? tgt_speed_q : diff9[7:0];
    assign dn_to_zero = diff9[8] ? 8'd0 : diff9[7:0];

    always_comb begin
        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        tgt_dir_d   = tgt_dir_q;
        tgt_speed_d = tgt_speed_q;
        speed_d     = speed_q;
        dead_d      = dead_q;

        if (estop) begin
            state_d     = StDead;
            speed_d     = 8'd0;
            dead_d      = DeadLoad;
            tgt_dir_d   = DirStop;
            tgt_speed_d = 8'd0;
        end else begin
            if (cmd_valid && (cmd_dir != DirRsvd)) begin
                tgt_dir_d   = cmd_dir;
                tgt_speed_d = cmd_speed;
            end

            // Transitions act on the registered target, one edge after the latch.
            unique case (state_q)
                StIdle: begin
                    speed_d = 8'd0;
                    if ((tgt_dir_q == DirFwd) || (tgt_dir_q == DirRev)) begin
                        cur_dir_d = tgt_dir_q;
                        state_d   = StRun;
                    end
                end
                StRun: begin
                    if (tgt_dir_q != cur_dir_q) begin
                        state_d = StDecel;
                    end else if (tick) begin
                        if (speed_q < tgt_speed_q) begin
                            speed_d = up_to_tgt;
                        end else if (speed_q > tgt_speed_q) begin
                            speed_d = dn_to_tgt;
                        end
                    end
                end
                StDecel: begin
                    if (tgt_dir_q == cur_dir_q) begin
                        state_d = StRun;
                    end else if (speed_q == 8'd0) begin
                        if (tgt_dir_q == DirStop) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StDead;
                            dead_d  = DeadLoad;
                        end
                    end else if (tick) begin
                        speed_d = dn_to_zero;
                    end
                end
                StDead: begin
                    speed_d = 8'd0;
                    if (dead_q == '0) begin
                        if (tgt_dir_q == DirStop) begin
                            state_d = StIdle;
                        end else begin
                            cur_dir_d = tgt_dir_q;
                            state_d   = StRun;
                        end
                    end else begin
                        dead_d = dead_q - DeadW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Enables follow the next state so they switch on the same edge.
        en1_d = ((state_d == StRun) || (state_d == StDecel)) && (cur_dir_d == DirFwd);
        en2_d = ((state_d == StRun) || (state_d == StDecel)) && (cur_dir_d == DirRev);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cur_dir_q   <= DirStop;
            tgt_dir_q   <= DirStop;
            tgt_speed_q <= 8'd0;
            speed_q     <= 8'd0;
            dead_q      <= '0;
            en1_q       <= 1'b0;
            en2_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_dir_q   <= cur_dir_d;
            tgt_dir_q   <= tgt_dir_d;
            tgt_speed_q <= tgt_speed_d;
            speed_q     <= speed_d;
            dead_q      <= dead_d;
            en1_q       <= en1_d;
            en2_q       <= en2_d;
        end
    end

    assign en_dir1 = en1_q;
    assign en_dir2 = en2_q;
    assign speed   = speed_q;
    assign busy    = (state_q == StDecel) || (state_q == StDead) ||
                     ((state_q == StRun) && (speed_q != tgt_speed_q));

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: constant vector table, directed multi-cycle
// sequences, and a randomized run against a behavioural model.
module tb_motor_ramp_ctrl;

    localparam int RD = 4;
    localparam int ST = 16;
    localparam int DC = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic [7:0] cmd_speed;
    logic       estop;
    logic       en_dir1;
    logic       en_dir2;
    logic [7:0] speed;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    motor_ramp_ctrl #(
        .RAMP_DIV   (RD),
        .STEP       (ST),
        .DEAD_CYCLES(DC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .cmd_valid(cmd_valid),
        .cmd_dir  (cmd_dir),
        .cmd_speed(cmd_speed),
        .estop    (estop),
        .en_dir1  (en_dir1),
        .en_dir2  (en_dir2),
        .speed    (speed),
        .busy     (busy)
    );

    typedef struct {
        logic        rst;
        logic        cv;
        logic [1:0]  dir;
        logic [7:0]  spd;
        int          n;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[18];
    int   exp_rev_a[7] = '{84, 68, 52, 36, 20, 4, 0};
    int   exp_rev_b[4] = '{16, 32, 48, 50};

    function automatic logic [10:0] o(logic e1, logic e2, logic [7:0] s, logic b);
        return {e1, e2, s, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        check("excl", {31'd0, en_dir1 & en_dir2}, 32'd0);
    endtask

    task automatic send_cmd(input logic [1:0] d, input logic [7:0] s);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_speed = s;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_settled(input string name, input logic [7:0] s, input int limit);
        int n = 0;
        while (!(busy === 1'b0 && speed === s) && n < limit) begin
            step();
            n++;
        end
        check(name, {busy, speed}, {1'b0, s});
    endtask

    // Behavioural model: mode numbers, remaining dead cycles, cycles since reset.
    localparam int MIdle = 0, MRun = 1, MDecel = 2, MDead = 3;
    int m_mode, m_cur, m_tdir, m_tspd, m_spd, m_cyc, m_dead_left;

    task automatic model_step(input bit rst, input bit cv, input int d, input int s,
                              input bit es);
        bit tick;
        if (rst) begin
            m_mode = MIdle; m_cur = 0; m_tdir = 0; m_tspd = 0;
            m_spd = 0; m_cyc = 0; m_dead_left = 0;
            return;
        end
        tick = (m_cyc % RD) == RD - 1;
        m_cyc++;
        if (es) begin
            m_mode = MDead; m_dead_left = DC; m_spd = 0; m_tdir = 0; m_tspd = 0;
            return;
        end
        case (m_mode)
            MIdle: if (m_tdir == 1 || m_tdir == 2) begin
                m_cur = m_tdir;
                m_mode = MRun;
            end
            MRun: begin
                if (m_tdir != m_cur) m_mode = MDecel;
                else if (tick && m_spd < m_tspd)
                    m_spd = (m_spd + ST < m_tspd) ? m_spd + ST : m_tspd;
                else if (tick && m_spd > m_tspd)
                    m_spd = (m_spd - ST > m_tspd) ? m_spd - ST : m_tspd;
            end
            MDecel: begin
                if (m_tdir == m_cur) m_mode = MRun;
                else if (m_spd == 0) begin
                    if (m_tdir == 0) m_mode = MIdle;
                    else begin
                        m_mode = MDead;
                        m_dead_left = DC;
                    end
                end else if (tick) m_spd = (m_spd > ST) ? m_spd - ST : 0;
            end
            default: begin
                if (m_dead_left <= 1) begin
                    if (m_tdir == 0) m_mode = MIdle;
                    else begin
                        m_cur = m_tdir;
                        m_mode = MRun;
                    end
                end else m_dead_left--;
            end
        endcase
        if (cv && d != 3) begin
            m_tdir = d;
            m_tspd = s;
        end
    endtask

    function automatic logic [10:0] model_out();
        logic on;
        logic b;
        on = (m_mode == MRun) || (m_mode == MDecel);
        b  = (m_mode == MDecel) || (m_mode == MDead) || (m_mode == MRun && m_spd != m_tspd);
        return {on && m_cur == 1, on && m_cur == 2, 8'(m_spd), b};
    endfunction

    initial begin
        int last;
        int n;
        int qa[$];
        int qb[$];
        int dead;
        bit saw_off;

        RST = 1'b0; cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_speed = 8'd0; estop = 1'b0;

        // Reset with a competing command, forward ramp to 100, retarget, reserved dir.
        tbl[0]  = '{1'b1, 1'b1, 2'b01, 8'd100, 3, o(0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 1'b0, 2'b01, 8'd100, 2, o(0, 0, 0, 0)};
        tbl[2]  = '{1'b0, 1'b1, 2'b01, 8'd100, 1, o(0, 0, 0, 0)};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, 8'd0,   1, o(1, 0, 0, 1)};
        tbl[4]  = '{1'b0, 1'b0, 2'b00, 8'd0,   4, o(1, 0, 16, 1)};
        tbl[5]  = '{1'b0, 1'b0, 2'b00, 8'd0,   3, o(1, 0, 16, 1)};
        tbl[6]  = '{1'b0, 1'b0, 2'b00, 8'd0,   1, o(1, 0, 32, 1)};
        tbl[7]  = '{1'b0, 1'b0, 2'b00, 8'd0,   4, o(1, 0, 48, 1)};
        tbl[8]  = '{1'b0, 1'b0, 2'b00, 8'd0,   4, o(1, 0, 64, 1)};
        tbl[9]  = '{1'b0, 1'b0, 2'b00, 8'd0,   4, o(1, 0, 80, 1)};
        tbl[10] = '{1'b0, 1'b0, 2'b00, 8'd0,   4, o(1, 0, 96, 1)};
        tbl[11] = '{1'b0, 1'b0, 2'b00, 8'd0,   4, o(1, 0, 100, 0)};
        tbl[12] = '{1'b0, 1'b0, 2'b00, 8'd0,   4, o(1, 0, 100, 0)};
        tbl[13] = '{1'b0, 1'b1, 2'b01, 8'd64,  1, o(1, 0, 100, 1)};
        tbl[14] = '{1'b0, 1'b0, 2'b00, 8'd0,   3, o(1, 0, 84, 1)};
        tbl[15] = '{1'b0, 1'b0, 2'b00, 8'd0,   8, o(1, 0, 64, 0)};
        tbl[16] = '{1'b0, 1'b1, 2'b11, 8'd7,   1, o(1, 0, 64, 0)};
        tbl[17] = '{1'b0, 1'b0, 2'b00, 8'd0,   8, o(1, 0, 64, 0)};

        for (int i = 0; i < 18; i++) begin
            RST = tbl[i].rst; cmd_valid = tbl[i].cv;
            cmd_dir = tbl[i].dir; cmd_speed = tbl[i].spd;
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d", i), {en_dir1, en_dir2, speed, busy}, tbl[i].exp);
        end
        RST = 1'b0; cmd_valid = 1'b0;

        // Reversal 100 fwd -> 50 rev.
        send_cmd(2'b01, 8'd100);
        wait_settled("rev_setup", 8'd100, 100);
        send_cmd(2'b10, 8'd50);
        last = speed; dead = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (en_dir1 && !en_dir2) begin
                if (speed != last) qa.push_back(speed);
            end else if (!en_dir1 && !en_dir2) begin
                dead++;
            end else if (en_dir2 && !en_dir1) begin
                if (speed != last) qb.push_back(speed);
                if (speed == 8'd50 && !busy) break;
            end
            last = speed;
        end
        check("rev_decel_len", qa.size(), 7);
        for (int i = 0; i < 7; i++)
            check($sformatf("rev_decel%0d", i), (i < qa.size()) ? qa[i] : -1, exp_rev_a[i]);
        check("rev_dead_len", dead, DC);
        check("rev_ramp_len", qb.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rev_ramp%0d", i), (i < qb.size()) ? qb[i] : -1, exp_rev_b[i]);

        // Stop, then saturating ramp to 255.
        send_cmd(2'b00, 8'd0);
        wait_settled("stop_idle", 8'd0, 100);
        check("stop_en", {en_dir1, en_dir2}, 2'b00);
        send_cmd(2'b01, 8'd255);
        qa.delete();
        last = speed;
        for (int i = 0; i < 300 && !(speed == 8'd255 && !busy); i++) begin
            step();
            if (speed != last) qa.push_back(speed);
            last = speed;
        end
        check("sat_len", qa.size(), 16);
        for (int k = 0; k < 16; k++)
            check($sformatf("sat%0d", k), (k < qa.size()) ? qa[k] : -1,
                  (k == 15) ? 255 : 16 * (k + 1));

        // Abort a reversal mid-decel: back to RUN with no dead time.
        send_cmd(2'b10, 8'd30);
        n = 0;
        while (speed > 8'd200 && n < 100) begin
            step();
            n++;
        end
        check("abort_decel", {31'd0, speed <= 8'd200}, 32'd1);
        send_cmd(2'b01, 8'd255);
        saw_off = 1'b0;
        for (int i = 0; i < 200 && !(speed == 8'd255 && !busy); i++) begin
            step();
            if (!en_dir1 || speed == 8'd0) saw_off = 1'b1;
        end
        check("abort_no_dead", {31'd0, saw_off}, 32'd0);
        check("abort_final", {en_dir1, speed, busy}, {1'b1, 8'd255, 1'b0});

        // estop at 128 fwd with a simultaneous reverse command.
        send_cmd(2'b01, 8'd128);
        wait_settled("estop_setup", 8'd128, 100);
        estop = 1'b1; cmd_valid = 1'b1; cmd_dir = 2'b10; cmd_speed = 8'd200;
        step();
        estop = 1'b0; cmd_valid = 1'b0;
        check("estop_out", {en_dir1, en_dir2, speed, busy}, o(0, 0, 0, 1));
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            step();
        end
        check("estop_dead_len", n, DC);
        saw_off = 1'b0;
        repeat (20) begin
            step();
            if (en_dir1 || en_dir2 || speed != 8'd0 || busy) saw_off = 1'b1;
        end
        check("estop_cmd_dropped", {31'd0, saw_off}, 32'd0);

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            RST   = (c == 0) || ($urandom_range(0, 499) == 0);
            estop = ($urandom_range(0, 79) == 0);
            cmd_valid = ($urandom_range(0, 9) == 0);
            cmd_dir   = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 3);
            cmd_speed = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
            model_step(RST, cmd_valid, cmd_dir, cmd_speed, estop);
            step();
            check("rand", {en_dir1, en_dir2, speed, busy}, model_out());
        end
        RST = 1'b0; estop = 1'b0; cmd_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
